// File: rtl/phy_tx_scheduler.sv
// PCIe PHY transmit sequencer: round-robin TLP/DLLP framing, IDL fill and periodic
// SKP ordered sets inserted only at packet boundaries.
module phy_tx_scheduler #(
  parameter int SKP_INTERVAL = 64,
  parameter int CNT_W        = 8
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       TLP_REQ,
  input  logic [7:0] TLP_LEN,
  input  logic [7:0] TLP_DATA,
  input  logic       TLP_NULLIFY,
  output logic       TLP_GNT,
  output logic       TLP_RD,
  input  logic       DLLP_REQ,
  input  logic [7:0] DLLP_DATA,
  output logic       DLLP_GNT,
  output logic       DLLP_RD,
  output logic [1:0] CONTROL,
  output logic [7:0] D,
  output logic [7:0] START_END,
  output logic [7:0] ORDERED_SET,
  output logic [7:0] LOG_COM,
  output logic       BUSY
);

  localparam logic [7:0] SYM_STP = 8'hfb;
  localparam logic [7:0] SYM_SDP = 8'h5c;
  localparam logic [7:0] SYM_END = 8'hfd;
  localparam logic [7:0] SYM_EDB = 8'hfe;
  localparam logic [7:0] SYM_IDL = 8'h7c;
  localparam logic [7:0] SYM_SKP = 8'h1c;
  localparam logic [7:0] SYM_COM = 8'hbc;

  localparam logic [1:0] CTL_D   = 2'b00;
  localparam logic [1:0] CTL_SE  = 2'b01;
  localparam logic [1:0] CTL_OS  = 2'b10;
  localparam logic [1:0] CTL_COM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_END, S_SKP_COM, S_SKP_SET
  } state_t;

  state_t           r_state, w_next_state;
  logic             r_sel_tlp, r_last_tlp, r_nullify;
  logic [7:0]       r_remain;
  logic [CNT_W-1:0] r_skp_cnt;
  logic [1:0]       r_skp_phase;

  logic [1:0] r_control, w_control;
  logic [7:0] r_start_end, w_start_end, r_ordered_set, w_ordered_set;
  logic       r_tlp_gnt, w_tlp_gnt, r_dllp_gnt, w_dllp_gnt;
  logic       r_tlp_rd, w_tlp_rd, r_dllp_rd, w_dllp_rd, r_busy, w_busy;

  logic       w_skp_pending, w_decision, w_pick_tlp, w_null_now;
  logic [7:0] w_tlp_len;

  // The counter saturates at the threshold, so reaching it is the pending flag.
  assign w_skp_pending = (r_skp_cnt == CNT_W'(SKP_INTERVAL - 1));
  assign w_decision    = (r_state == S_IDLE) || (r_state == S_END) ||
                         ((r_state == S_SKP_SET) && (r_skp_phase == 2'd2));
  assign w_pick_tlp    = TLP_REQ && (!DLLP_REQ || !r_last_tlp);
  assign w_tlp_len     = (TLP_LEN == 8'd0) ? 8'd1 : TLP_LEN;
  assign w_null_now    = (r_state == S_DATA) && r_sel_tlp && TLP_NULLIFY;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_next_state  = r_state;
    w_control     = CTL_OS;
    w_start_end   = 8'h00;
    w_ordered_set = SYM_IDL;
    w_tlp_gnt     = 1'b0;
    w_dllp_gnt    = 1'b0;
    w_tlp_rd      = 1'b0;
    w_dllp_rd     = 1'b0;
    w_busy        = 1'b1;

    if (w_decision) begin
      if (w_skp_pending)            w_next_state = S_SKP_COM;
      else if (TLP_REQ || DLLP_REQ) w_next_state = S_START;
      else                          w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_START:   w_next_state = S_DATA;
        S_DATA:    if (r_remain == 8'd1) w_next_state = S_END;
        S_SKP_COM: w_next_state = S_SKP_SET;
        default:   w_next_state = r_state;
      endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    unique case (w_next_state)
      S_IDLE:    w_busy = 1'b0;
      S_START: begin
        w_control   = CTL_SE;
        w_start_end = w_pick_tlp ? SYM_STP : SYM_SDP;
        w_tlp_gnt   = w_pick_tlp;
        w_dllp_gnt  = !w_pick_tlp;
      end
      S_DATA: begin
        w_control = CTL_D;
        w_tlp_rd  = r_sel_tlp;
        w_dllp_rd = !r_sel_tlp;
      end
      S_END: begin
        w_control   = CTL_SE;
        w_start_end = (r_nullify || w_null_now) ? SYM_EDB : SYM_END;
      end
      S_SKP_COM: w_control = CTL_COM;
      S_SKP_SET: w_ordered_set = SYM_SKP;
      default:   w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state       <= S_IDLE;
      r_sel_tlp     <= 1'b0;
      r_last_tlp    <= 1'b0;
      r_nullify     <= 1'b0;
      r_remain      <= 8'd0;
      r_skp_cnt     <= '0;
      r_skp_phase   <= 2'd0;
      r_control     <= CTL_OS;
      r_start_end   <= 8'h00;
      r_ordered_set <= SYM_IDL;
      r_tlp_gnt     <= 1'b0;
      r_dllp_gnt    <= 1'b0;
      r_tlp_rd      <= 1'b0;
      r_dllp_rd     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_next_state;
      r_control     <= w_control;
      r_start_end   <= w_start_end;
      r_ordered_set <= w_ordered_set;
      r_tlp_gnt     <= w_tlp_gnt;
      r_dllp_gnt    <= w_dllp_gnt;
      r_tlp_rd      <= w_tlp_rd;
      r_dllp_rd     <= w_dllp_rd;
      r_busy        <= w_busy;

      if (w_next_state == S_START) begin
        r_sel_tlp  <= w_pick_tlp;
        r_last_tlp <= w_pick_tlp;
        r_remain   <= w_pick_tlp ? w_tlp_len : 8'd6;
      end else if (r_state == S_DATA) begin
        r_remain <= r_remain - 8'd1;
      end

      if (r_state == S_END)  r_nullify <= 1'b0;
      else if (w_null_now)   r_nullify <= 1'b1;

      if (w_next_state == S_SKP_COM) r_skp_cnt <= '0;
      else if (!w_skp_pending)       r_skp_cnt <= r_skp_cnt + 1'b1;

      if (r_state == S_SKP_COM)      r_skp_phase <= 2'd0;
      else if (r_state == S_SKP_SET) r_skp_phase <= r_skp_phase + 2'd1;
    end
  end

  // D bypasses the output registers so a show-ahead byte reaches the encoder in its RD cycle.
  assign D           = (r_state == S_DATA) ? (r_sel_tlp ? TLP_DATA : DLLP_DATA) : 8'h00;
  assign CONTROL     = r_control;
  assign START_END   = r_start_end;
  assign ORDERED_SET = r_ordered_set;
  assign LOG_COM     = SYM_COM;
  assign TLP_GNT     = r_tlp_gnt;
  assign DLLP_GNT    = r_dllp_gnt;
  assign TLP_RD      = r_tlp_rd;
  assign DLLP_RD     = r_dllp_rd;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: show-ahead TLP/DLLP sources plus a symbol-stream model
// that expands each boundary decision into the expected per-cycle output sequence.
module tb_phy_tx_scheduler;

  localparam int SKP_INTERVAL = 64;
  localparam logic [7:0] STP = 8'hfb, SDP = 8'h5c, ENDS = 8'hfd, EDB = 8'hfe;
  localparam logic [7:0] IDL = 8'h7c, SKP = 8'h1c, COM = 8'hbc;

  typedef struct packed {
    logic [1:0] ctl;
    logic [7:0] se;
    logic [7:0] os;
    logic [7:0] d;
    logic       tg;
    logic       dg;
    logic       tr;
    logic       dr;
    logic       busy;
  } sym_t;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b1;
  logic       TLP_REQ, TLP_NULLIFY, DLLP_REQ;
  logic [7:0] TLP_LEN, TLP_DATA, DLLP_DATA;
  logic       TLP_GNT, TLP_RD, DLLP_GNT, DLLP_RD, BUSY;
  logic [1:0] CONTROL;
  logic [7:0] D, START_END, ORDERED_SET, LOG_COM;

  phy_tx_scheduler #(.SKP_INTERVAL(SKP_INTERVAL), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_L(RESET_L),
    .TLP_REQ(TLP_REQ), .TLP_LEN(TLP_LEN), .TLP_DATA(TLP_DATA), .TLP_NULLIFY(TLP_NULLIFY),
    .TLP_GNT(TLP_GNT), .TLP_RD(TLP_RD),
    .DLLP_REQ(DLLP_REQ), .DLLP_DATA(DLLP_DATA), .DLLP_GNT(DLLP_GNT), .DLLP_RD(DLLP_RD),
    .CONTROL(CONTROL), .D(D), .START_END(START_END), .ORDERED_SET(ORDERED_SET),
    .LOG_COM(LOG_COM), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int   errors = 0, checks = 0;
  int   t = 0, t_base = -1, first_com_t = -1, rel_t = 0;
  int   tlp_rd_cnt = 0, edb_cnt = 0, n = 0;
  bit   last_tlp = 1'b0, rand_mode = 1'b0, null_en = 1'b0;
  sym_t exp_q[$];
  bit   gnt_log[$];

  bit         tlp_pv = 0, dllp_pv = 0, tlp_hold = 0, dllp_hold = 0;
  int         tlp_refill = 0, dllp_refill = 0, tlp_idx = 0, dllp_idx = 0;
  logic [7:0] tlp_pend_len = 8'd0;
  logic [7:0] tlp_pend_b [256], tlp_act_b [256], dllp_pend_b [256], dllp_act_b [256];
  bit         tlp_pend_n [256], tlp_act_n [256];
  logic       s_tlp_gnt = 0, s_dllp_gnt = 0, s_tlp_rd = 0, s_dllp_rd = 0, s_busy = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%02h expected=%02h", tag, t, obs, exp_v);
    end
  endtask

  function automatic sym_t mk(input logic [1:0] ctl, input logic [7:0] se, input logic [7:0] os,
                              input logic [7:0] d, input logic tg, input logic dg,
                              input logic tr, input logic dr, input logic busy);
    sym_t s;
    s.ctl = ctl; s.se = se; s.os = os; s.d = d;
    s.tg = tg; s.dg = dg; s.tr = tr; s.dr = dr; s.busy = busy;
    return s;
  endfunction

  function automatic int rand_len();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(13, 255));
    return int'($urandom_range(0, 12));
  endfunction

  task automatic make_tlp(input int len);
    tlp_pv = 1'b1;
    tlp_pend_len = 8'(len);
    for (int i = 0; i < 256; i++) begin
      tlp_pend_b[i] = 8'($urandom);
      tlp_pend_n[i] = null_en && ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic make_dllp();
    dllp_pv = 1'b1;
    for (int i = 0; i < 256; i++) dllp_pend_b[i] = 8'($urandom);
  endtask

  task automatic drive();
    TLP_REQ     = tlp_pv;
    TLP_LEN     = tlp_pend_len;
    TLP_DATA    = tlp_act_b[tlp_idx % 256];
    TLP_NULLIFY = tlp_act_n[tlp_idx % 256];
    DLLP_REQ    = dllp_pv;
    DLLP_DATA   = dllp_act_b[dllp_idx % 256];
  endtask

  // Expand one boundary decision into the symbols of the following cycles.
  task automatic decide();
    bit pick, nul;
    int len;
    if (t - t_base >= SKP_INTERVAL - 1) begin
      exp_q.push_back(mk(2'b11, 8'h00, IDL, 8'h00, 0, 0, 0, 0, 1));
      repeat (3) exp_q.push_back(mk(2'b10, 8'h00, SKP, 8'h00, 0, 0, 0, 0, 1));
      t_base = t + 1;
    end else if (TLP_REQ || DLLP_REQ) begin
      pick = TLP_REQ && (!DLLP_REQ || !last_tlp);
      last_tlp = pick;
      len = pick ? ((TLP_LEN == 8'd0) ? 1 : int'(TLP_LEN)) : 6;
      nul = 1'b0;
      exp_q.push_back(mk(2'b01, pick ? STP : SDP, IDL, 8'h00, pick, !pick, 0, 0, 1));
      for (int i = 0; i < len; i++) begin
        if (pick && tlp_pend_n[i]) nul = 1'b1;
        exp_q.push_back(mk(2'b00, 8'h00, IDL, pick ? tlp_pend_b[i] : dllp_pend_b[i],
                           0, 0, pick, !pick, 1));
      end
      exp_q.push_back(mk(2'b01, nul ? EDB : ENDS, IDL, 8'h00, 0, 0, 0, 0, 1));
      if (pick) tlp_hold = 1'b1;
      else      dllp_hold = 1'b1;
    end else begin
      exp_q.push_back(mk(2'b10, 8'h00, IDL, 8'h00, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic tick();
    sym_t e;
    @(posedge CLK);
    #1;
    if (s_tlp_rd)  tlp_idx++;
    if (s_dllp_rd) dllp_idx++;
    if (s_tlp_gnt) begin
      for (int i = 0; i < 256; i++) begin
        tlp_act_b[i] = tlp_pend_b[i];
        tlp_act_n[i] = tlp_pend_n[i];
      end
      tlp_idx = 0; tlp_pv = 1'b0; tlp_hold = 1'b0;
      if (tlp_refill > 0) begin make_tlp(int'($urandom_range(1, 12))); tlp_refill--; end
    end
    if (s_dllp_gnt) begin
      for (int i = 0; i < 256; i++) dllp_act_b[i] = dllp_pend_b[i];
      dllp_idx = 0; dllp_pv = 1'b0; dllp_hold = 1'b0;
      if (dllp_refill > 0) begin make_dllp(); dllp_refill--; end
    end
    if (rand_mode) begin
      if (!tlp_pv && $urandom_range(0, 9) == 0) make_tlp(rand_len());
      else if (tlp_pv && !tlp_hold && $urandom_range(0, 63) == 0) tlp_pv = 1'b0;
      if (!dllp_pv && $urandom_range(0, 11) == 0) make_dllp();
    end
    drive();
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("control",     8'(CONTROL),  8'(e.ctl));
      check("start_end",   START_END,    e.se);
      check("ordered_set", ORDERED_SET,  e.os);
      check("d",           D,            e.d);
      check("log_com",     LOG_COM,      COM);
      check("tlp_gnt",     8'(TLP_GNT),  8'(e.tg));
      check("dllp_gnt",    8'(DLLP_GNT), 8'(e.dg));
      check("tlp_rd",      8'(TLP_RD),   8'(e.tr));
      check("dllp_rd",     8'(DLLP_RD),  8'(e.dr));
      check("busy",        8'(BUSY),     8'(e.busy));
    end
    if (TLP_RD) tlp_rd_cnt++;
    if (TLP_GNT) gnt_log.push_back(1'b1);
    if (DLLP_GNT) gnt_log.push_back(1'b0);
    if (CONTROL == 2'b01 && START_END == EDB) edb_cnt++;
    if (CONTROL == 2'b11 && first_com_t < 0) first_com_t = t;
    s_tlp_gnt = TLP_GNT; s_dllp_gnt = DLLP_GNT;
    s_tlp_rd = TLP_RD; s_dllp_rd = DLLP_RD; s_busy = BUSY;
    if (exp_q.size() == 0) decide();
    t++;
  endtask

  task automatic run_until_idle(input int max);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((tlp_pv || dllp_pv || s_busy) && k < max);
    check("idle_reached", 8'(k < max), 8'd1);
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    tlp_pv = 0; dllp_pv = 0; tlp_hold = 0; dllp_hold = 0;
    tlp_refill = 0; dllp_refill = 0; tlp_idx = 0; dllp_idx = 0;
    drive();
    #1;
    check("rst_control",     8'(CONTROL),  8'h02);
    check("rst_ordered_set", ORDERED_SET,  IDL);
    check("rst_start_end",   START_END,    8'h00);
    check("rst_d",           D,            8'h00);
    check("rst_log_com",     LOG_COM,      COM);
    check("rst_tlp_gnt",     8'(TLP_GNT),  8'h00);
    check("rst_dllp_gnt",    8'(DLLP_GNT), 8'h00);
    check("rst_tlp_rd",      8'(TLP_RD),   8'h00);
    check("rst_dllp_rd",     8'(DLLP_RD),  8'h00);
    check("rst_busy",        8'(BUSY),     8'h00);
    repeat (2) begin
      @(negedge CLK);
      check("rst_hold_tlp_rd",  8'(TLP_RD),  8'h00);
      check("rst_hold_control", 8'(CONTROL), 8'h02);
    end
    @(negedge CLK);
    RESET_L = 1'b1;
    exp_q.delete();
    exp_q.push_back(mk(2'b10, 8'h00, IDL, 8'h00, 0, 0, 0, 0, 0));
    last_tlp = 1'b0;
    t_base = t - 1;
    s_tlp_gnt = 0; s_dllp_gnt = 0; s_tlp_rd = 0; s_dllp_rd = 0; s_busy = 0;
    first_com_t = -1;
    rel_t = t;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tlp_act_b[i] = 8'h00; tlp_act_n[i] = 1'b0; dllp_act_b[i] = 8'h00;
      tlp_pend_b[i] = 8'h00; tlp_pend_n[i] = 1'b0; dllp_pend_b[i] = 8'h00;
    end
    drive();
    #2;
    do_reset();

    // Single TLP of four walking-one bytes.
    make_tlp(4);
    tlp_pend_b[0] = 8'h01; tlp_pend_b[1] = 8'h02; tlp_pend_b[2] = 8'h04; tlp_pend_b[3] = 8'h08;
    tlp_rd_cnt = 0;
    run_until_idle(200);
    check("tlp4_rd_cycles", 8'(tlp_rd_cnt), 8'd4);

    // Single DLLP.
    gnt_log.delete();
    make_dllp();
    run_until_idle(200);
    check("dllp_gnt_count", 8'(gnt_log.size()), 8'd1);

    // Both sources requesting: round-robin, back-to-back.
    gnt_log.delete();
    make_tlp(5);
    make_dllp();
    tlp_refill = 1;
    run_until_idle(300);
    check("rr_gnt_count", 8'(gnt_log.size()), 8'd3);
    if (gnt_log.size() == 3)
      check("rr_gnt_order", 8'({gnt_log[0], gnt_log[1], gnt_log[2]}), 8'b101);

    // Long TLP straddling the SKP threshold.
    make_tlp(200);
    run_until_idle(600);

    // Nullified TLP, then a clean one.
    edb_cnt = 0;
    make_tlp(3);
    tlp_pend_n[1] = 1'b1;
    tlp_refill = 1;
    run_until_idle(300);
    check("edb_count", 8'(edb_cnt), 8'd1);

    // Randomized traffic with nullify and request withdrawal.
    null_en = 1'b1;
    rand_mode = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    null_en = 1'b0;
    run_until_idle(800);

    // Reset in the second data byte, then the SKP interval restarts from zero.
    make_tlp(8);
    tlp_rd_cnt = 0;
    n = 0;
    while (tlp_rd_cnt < 2 && n < 300) begin
      tick();
      n++;
    end
    check("reach_byte2", 8'(tlp_rd_cnt), 8'd2);
    #2;
    do_reset();
    repeat (70) tick();
    check("skp_after_reset", 8'(first_com_t - rel_t), 8'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
